// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter: the master drives en/load/load_val
// and observes the count, the terminal-count pulse and busy.
interface sync_down_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  modport master (output en, load, load_val, input Q, tc, busy);
  modport slave  (input en, load, load_val, output Q, tc, busy);
endinterface

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with one-cycle terminal-count pulse.
// Define SYNC_DOWN_CNT_RELOAD_EN for periodic reload; otherwise one-shot.
module sync_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  sync_down_counter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_busy;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_dec;

  // Borrow chain: a bit flips when every lower bit is already 0.
  assign w_tog[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign w_tog[i] = w_tog[i-1] & ~r_q[i-1];
  end
  assign w_dec = r_q ^ w_tog;

`ifdef SYNC_DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (reset) r_reload <= '0;
    else if (bus.load) r_reload <= bus.load_val;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.load) begin
        r_q <= bus.load_val;
        if (bus.load_val != '0) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else if (r_state == RUN && bus.en) begin
        if (r_q == WIDTH'(1)) begin
          r_tc <= 1'b1;
`ifdef SYNC_DOWN_CNT_RELOAD_EN
          r_q  <= r_reload;
`else
          r_q     <= '0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end else begin
          r_q <= w_dec;
        end
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_sync_down_counter.sv
// Vector-table bench for sync_down_counter (WIDTH=3); expectations follow the
// build mode selected by SYNC_DOWN_CNT_RELOAD_EN.
module tb_sync_down_counter;
  localparam int W = 3;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
  } vec_t;

  typedef struct {
    int           tag;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t sb[$];

  sync_down_counter_if #(.WIDTH(W)) sif ();
  sync_down_counter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(sif.slave));

  always #5 clk = ~clk;

  function automatic void add(logic rst, logic ld, logic [W-1:0] lv, logic en,
                              logic [W-1:0] q, logic tc, logic busy);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.en = en;
    v.q = q; v.tc = tc; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic cmp(int tag, logic [W-1:0] q, logic tc, logic busy);
    n_cmp++;
    if (sif.Q !== q || sif.tc !== tc || sif.busy !== busy) begin
      n_bad++;
      $display("FAIL vec%0d: got Q=%0d tc=%b busy=%b, want Q=%0d tc=%b busy=%b",
               tag, sif.Q, sif.tc, sif.busy, q, tc, busy);
    end
  endtask

  task automatic apply(int tag, vec_t v);
    exp_t e;
    reset = v.rst; sif.load = v.ld; sif.load_val = v.lv; sif.en = v.en;
    e.tag = tag; e.q = v.q; e.tc = v.tc; e.busy = v.busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp(e.tag, e.q, e.tc, e.busy);
  endtask

  initial begin
    int edges;
    bit got_tc;
    sif.en = 1'b0; sif.load = 1'b0; sif.load_val = '0;

    // reset dominates a simultaneous load
    for (int i = 0; i < 3; i++) add(1, 1, 5, 0, 0, 0, 0);
`ifdef SYNC_DOWN_CNT_RELOAD_EN
    add(0, 1, 3, 0, 3, 0, 1);
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 0, 1, 2, 0, 1);
      add(0, 0, 0, 1, 1, 0, 1);
      add(0, 0, 0, 1, 3, 1, 1);
    end
`else
    add(0, 1, 5, 0, 5, 0, 1);
    add(0, 0, 0, 1, 4, 0, 1);
    add(0, 0, 0, 1, 3, 0, 1);
    add(0, 0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
`endif
    // enable gaps
    add(0, 1, 4, 0, 4, 0, 1);
    add(0, 0, 0, 1, 3, 0, 1);
    add(0, 0, 0, 0, 3, 0, 1);
    add(0, 0, 0, 0, 3, 0, 1);
    add(0, 0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1);
`ifdef SYNC_DOWN_CNT_RELOAD_EN
    add(0, 0, 0, 1, 4, 1, 1);
`else
    add(0, 0, 0, 1, 0, 1, 0);
`endif
    // load beats a would-be terminal transition; load 0 goes idle
    add(0, 1, 2, 0, 2, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 1, 6, 1, 6, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
`ifdef SYNC_DOWN_CNT_RELOAD_EN
    add(0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 1, 1, 1);
`else
    add(0, 1, 7, 0, 7, 0, 1);
    for (int k = 6; k >= 1; k--) add(0, 0, 0, 1, W'(k), 0, 1);
    add(0, 0, 0, 1, 0, 1, 0);
`endif
    // reset mid-run, then a normal count
    add(0, 1, 6, 0, 6, 0, 1);
    add(0, 0, 0, 1, 5, 0, 1);
    add(0, 0, 0, 1, 4, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 2, 0, 2, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
`ifdef SYNC_DOWN_CNT_RELOAD_EN
    add(0, 0, 0, 1, 2, 1, 1);
`else
    add(0, 0, 0, 1, 0, 1, 0);
`endif
    // reset on the terminal edge suppresses the pending tc
    add(0, 1, 2, 0, 2, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) apply(i, vecs[i]);

    // hand sequence: load max, hold, then count edges to the first tc
    reset = 1'b0; sif.load = 1'b1; sif.load_val = 7; sif.en = 1'b0;
    @(posedge clk); #1;
    cmp(100, 7, 0, 1);
    sif.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cmp(101 + i, 7, 0, 1);
    end
    sif.en = 1'b1;
    edges = 0;
    got_tc = 0;
    for (int i = 0; i < 20 && !got_tc; i++) begin
      @(posedge clk); #1;
      edges++;
      if (sif.tc === 1'b1) got_tc = 1;
    end
    n_cmp++;
    if (!got_tc || edges != 7) begin
      n_bad++;
      $display("FAIL max_count: got_tc=%b edges=%0d, want got_tc=1 edges=7", got_tc, edges);
    end
    sif.en = 1'b0;
    @(posedge clk); #1;
`ifdef SYNC_DOWN_CNT_RELOAD_EN
    cmp(110, 7, 0, 1);
`else
    cmp(110, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
